// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and helpers
//
// Purpose: state encoding for the receiver FSM and the baud divisor helper,
//          shared by uart_rx and the future uart_tx.
// Contents:
//   uart_rx_state_t  receiver FSM states
//   calc_div()       clocks per bit, truncated integer division
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA_S = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } uart_rx_state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1-style asynchronous serial receiver
//
// Purpose: synchronizes the raw RX pin, finds the start edge, samples every
//          bit at its middle and deserializes LSB first.
// Ports:
//   CLK        system clock
//   RESET      synchronous, active-high reset
//   RX         asynchronous serial line, idle high
//   DATA       last correctly received byte, bit 0 = first data bit on the wire
//   VALID      one-cycle strobe, DATA updated this cycle
//   FRAME_ERR  one-cycle strobe, stop bit sampled low
//   BUSY       high whenever the FSM is not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int DIV  = calc_div(CLK_FREQ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
      $error("uart_rx: DATA_BITS must be in 5..9");
    end
  endgenerate

  uart_rx_state_t       state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;

  // State is a flop, so BUSY is glitch-free without a separate register.
  assign BUSY = (state != IDLE);

  // The counter is compared against N-1 because it is cleared on the edge
  // that enters a state: an event at N cycles after entry sees count N-1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      rx_m      <= RX;
      rx_s      <= rx_m;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            // A start bit that is already gone at mid-bit is line noise.
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA_S;
              bit_cnt <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA_S: begin
          if (baud_cnt == DIV_M1) begin
            baud_cnt <= '0;
            // Enter at the MSB and shift right so the first bit ends at bit 0.
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        STOP: begin
          if (baud_cnt == DIV_M1) begin
            baud_cnt <= '0;
            // Leaving at mid-stop gives half a bit to catch a back-to-back start.
            if (rx_s) begin
              DATA  <= shift;
              VALID <= 1'b1;
              state <= IDLE;
            end else begin
              FRAME_ERR <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        BREAK: begin
          // Hold here for the whole low period so a break reports only once.
          baud_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at DIV = 16
module tb_uart_rx;

  logic       CLK;
  logic       RESET;
  logic       RX;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       BUSY;

  uart_rx #(
    .CLK_FREQ (1_600_000),
    .BAUD     (100_000),
    .DATA_BITS(8)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RX       (RX),
    .DATA     (DATA),
    .VALID    (VALID),
    .FRAME_ERR(FRAME_ERR),
    .BUSY     (BUSY)
  );

  // Driving RX at the negedge of cycle c: two sync flops plus the IDLE
  // decision put T at c+3, and the stop sample at T+8+9*16 = c+155.
  localparam int STROBE_LAT = 155;

  typedef struct {
    bit       is_err;
    bit [7:0] data;
    int       cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;
  bit [7:0] last_good;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe pops one expected entry and is compared against it.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (VALID && FRAME_ERR) begin
        check("valid_and_ferr_together", 1, 0);
      end
      if (VALID || FRAME_ERR) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'd0, VALID, FRAME_ERR}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_kind_ferr", int'(FRAME_ERR), int'(e.is_err));
          check("strobe_data", int'(DATA), int'(e.data));
          check("strobe_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Sends start, 8 data bits LSB first and the stop bit. Bit i ends at
  // floor((i+1)*num/den) cycles, so num/den = 33/2 gives a 16.5-cycle bit.
  // The stop level is left on the line when the task returns.
  task automatic send_frame(input bit [7:0] d, input bit stop,
                            input int num, input int den, input bit chk_busy);
    bit [9:0] bits;
    int c;
    int r;
    int bad_busy;
    bits = {stop, d, 1'b0};
    c = cyc;
    if (stop) begin
      sb.push_back('{is_err: 1'b0, data: d, cyc: c + STROBE_LAT});
      last_good = d;
    end else begin
      sb.push_back('{is_err: 1'b1, data: last_good, cyc: c + STROBE_LAT});
    end
    r = 0;
    bad_busy = 0;
    for (int i = 0; i < 10; i++) begin
      int dur;
      dur = ((i + 1) * num) / den - (i * num) / den;
      RX = bits[i];
      repeat (dur) begin
        @(negedge CLK);
        r++;
        if (chk_busy && (BUSY !== ((r >= 3) && (r < STROBE_LAT)))) bad_busy++;
      end
    end
    if (chk_busy) check("busy_profile_bad_cycles", bad_busy, 0);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int c;
    checks    = 0;
    errors    = 0;
    last_good = 8'h00;
    RX        = 1'b1;
    RESET     = 1'b1;
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    check("reset_data", int'(DATA), 0);
    check("reset_valid", int'(VALID), 0);
    check("reset_ferr", int'(FRAME_ERR), 0);
    check("reset_busy", int'(BUSY), 0);
    idle(10);

    // Single frame with BUSY profile.
    send_frame(8'hA5, 1'b1, 16, 1, 1'b1);
    idle(30);

    // Back-to-back, no idle between stop and next start.
    send_frame(8'h00, 1'b1, 16, 1, 1'b0);
    send_frame(8'hFF, 1'b1, 16, 1, 1'b0);
    idle(30);

    // Four-cycle glitch, rejected at mid start bit.
    c = cyc;
    RX = 1'b0;
    repeat (4) @(negedge CLK);
    RX = 1'b1;
    while (cyc < c + 10) @(negedge CLK);
    check("glitch_busy_before_mid", int'(BUSY), 1);
    @(negedge CLK);
    check("glitch_busy_after_mid", int'(BUSY), 0);
    idle(20);
    send_frame(8'h3C, 1'b1, 16, 1, 1'b0);
    idle(30);

    // Bad stop bit followed by a held-low line.
    send_frame(8'h55, 1'b0, 16, 1, 1'b0);
    repeat (50) @(negedge CLK);
    check("break_busy_mid_low", int'(BUSY), 1);
    repeat (50) @(negedge CLK);
    check("break_busy_end_low", int'(BUSY), 1);
    RX = 1'b1;
    repeat (5) @(negedge CLK);
    check("break_busy_after_high", int'(BUSY), 0);
    check("break_data_kept", int'(DATA), 8'h3C);
    idle(20);
    send_frame(8'hC3, 1'b1, 16, 1, 1'b0);
    idle(30);

    // Reset during data bit 4 of 0x81.
    RX = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX = (8'h81 >> i) & 1;
      repeat (16) @(negedge CLK);
    end
    RX = 1'b0;
    repeat (8) @(negedge CLK);
    check("abort_busy_before_reset", int'(BUSY), 1);
    RESET = 1'b1;
    RX    = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    last_good = 8'h00;
    @(negedge CLK);
    check("abort_data_cleared", int'(DATA), 0);
    check("abort_busy_cleared", int'(BUSY), 0);
    idle(200);
    send_frame(8'h7E, 1'b1, 16, 1, 1'b0);
    idle(30);

    // Slow line, 16.5 cycles per bit.
    send_frame(8'h96, 1'b1, 33, 2, 1'b0);
    idle(200);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not finish, cycle %0d expected below 20000", cyc);
    $fatal(1);
  end

endmodule
